// File: rtl/shift_sequencer_if.sv
// Command/result handshake bundle between a command source and shift_sequencer.
interface shift_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_cnt;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;

  modport master (
    output cmd_valid, cmd_data, cmd_dir, cmd_cnt, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_dir, cmd_cnt, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-step shift controller: accepts (operand, dir, count), steps a
// one-position shifter once per clock, then returns the result.

// One-position zero-fill shifter; l and r are never both asserted.
module shifter #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i,
  input  logic             l,
  input  logic             r,
  output logic [WIDTH-1:0] o
);
  // Select left shift, right shift, or hold.
  always_comb begin
    o = i;
    if (l)      o = {i[WIDTH-2:0], 1'b0};
    else if (r) o = {1'b0, i[WIDTH-1:1]};
  end
endmodule

module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3,
  parameter int OPS_W = 8
) (
  input  logic             clk,
  input  logic             nrst,
  shift_sequencer_if.slave bus,
  output logic             busy,
  output logic [OPS_W-1:0] ops_done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [OPS_W-1:0] ops_q, ops_d;
  logic             sh_l, sh_r;
  logic [WIDTH-1:0] sh_o;

  shifter #(.WIDTH(WIDTH)) u_shifter (
    .i (data_q),
    .l (sh_l),
    .r (sh_r),
    .o (sh_o)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      data_q  <= '0;
      res_q   <= '0;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      res_q   <= res_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      ops_q   <= ops_d;
    end
  end

  // Next-state, shifter select and register updates.
  // The result lives in its own register so res_data holds its last value
  // while a new operand is loaded and stepped through the shifter.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    res_d   = res_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    ops_d   = ops_q;
    sh_l    = 1'b0;
    sh_r    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          data_d = bus.cmd_data;
          dir_d  = bus.cmd_dir;
          rem_d  = bus.cmd_cnt;
          if (bus.cmd_cnt == '0) begin
            res_d   = bus.cmd_data;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        sh_l   = ~dir_q;
        sh_r   = dir_q;
        data_d = sh_o;
        rem_d  = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          res_d   = sh_o;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          ops_d   = ops_q + OPS_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = res_q;
  assign busy          = (state_q == SHIFT) || (state_q == DONE);
  assign ops_done      = ops_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: the driver queues expected results
// and result-valid cycles; a monitor checks them as results appear.
module tb_shift_sequencer;
  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       busy;
  logic [7:0] ops_done;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  typedef struct {
    logic [3:0] data;
    int         cyc;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic [3:0] d;
    logic       dir;
    logic [2:0] cnt;
    logic [3:0] exp;
  } vec_t;
  vec_t vecs[8];

  shift_sequencer_if #(.WIDTH(4), .CNT_W(3)) bus ();

  shift_sequencer #(.WIDTH(4), .CNT_W(3), .OPS_W(8)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .bus      (bus),
    .busy     (busy),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency at result-valid rise, data at result handshake.
  bit rose = 1'b0;
  always @(negedge clk) begin
    if (!nrst) begin
      rose = 1'b0;
    end else begin
      if (bus.res_valid && !rose) begin
        rose = 1'b1;
        if (q.size() == 0) check("unexpected_result", 1, 0);
        else               check("res_latency", cyc, q[0].cyc);
      end
      if (bus.res_valid && bus.res_ready) begin
        if (q.size() != 0) begin
          check("res_data", int'(bus.res_data), int'(q[0].data));
          void'(q.pop_front());
        end
        rose = 1'b0;
      end
    end
  end

  task automatic send_cmd(input logic [3:0] d, input logic dir, input logic [2:0] cnt,
                          input logic [3:0] exp, input bit push);
    int n = 0;
    @(posedge clk); #1;
    while (!bus.cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.cmd_ready) begin
      check("cmd_ready_timeout", 0, 1);
      return;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    bus.cmd_dir   = dir;
    bus.cmd_cnt   = cnt;
    if (push) q.push_back('{exp, cyc + 1 + int'(cnt)});
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic send_vec(input int k);
    send_cmd(vecs[k].d, vecs[k].dir, vecs[k].cnt, vecs[k].exp, 1'b1);
  endtask

  initial begin
    int n;
    int nb;
    vecs[0] = '{4'b0011, 1'b0, 3'd2, 4'b1100};
    vecs[1] = '{4'b1010, 1'b1, 3'd1, 4'b0101};
    vecs[2] = '{4'b1111, 1'b1, 3'd0, 4'b1111};
    vecs[3] = '{4'b1111, 1'b1, 3'd7, 4'b0000};
    vecs[4] = '{4'b0110, 1'b0, 3'd1, 4'b1100};
    vecs[5] = '{4'b1001, 1'b1, 3'd3, 4'b0001};
    vecs[6] = '{4'b0001, 1'b0, 3'd3, 4'b1000};
    vecs[7] = '{4'b0101, 1'b0, 3'd4, 4'b0000};

    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_cnt   = '0;
    bus.res_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ops_done", ops_done, 0);
    nrst = 1'b1;

    // Basic left shift, then right shift and zero count
    send_vec(0);
    drain();
    check("ops_after_1", ops_done, 1);
    send_vec(1);
    send_vec(2);
    drain();
    check("ops_after_3", ops_done, 3);

    // Over-long right shift with a stalled consumer
    bus.res_ready = 1'b0;
    send_vec(3);
    nb = 0;
    n = 0;
    while (!bus.res_valid && n < 50) begin
      if (busy) nb++;
      @(posedge clk); #1;
      n++;
    end
    check("shift_busy_cycles", nb, 7);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 4'b1010;
    bus.cmd_dir   = 1'b0;
    bus.cmd_cnt   = 3'd1;
    for (int i = 0; i < 5; i++) begin
      check("hold_res_valid", bus.res_valid, 1);
      check("hold_res_data", bus.res_data, 0);
      check("hold_cmd_ready", bus.cmd_ready, 0);
      check("hold_busy", busy, 1);
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk); #1;
    check("ignored_cmd_res_valid", bus.res_valid, 0);
    check("ops_after_4", ops_done, 4);

    for (int k = 4; k < 8; k++) send_vec(k);
    drain();
    check("ops_after_8", ops_done, 8);
    check("res_hold_idle", bus.res_data, 0);

    // Reset during SHIFT: no result, outputs back to reset values at once
    send_cmd(4'b0011, 1'b0, 3'd5, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    check("midrst_cmd_ready", bus.cmd_ready, 1);
    check("midrst_res_valid", bus.res_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_res_data", bus.res_data, 0);
    check("midrst_ops_done", ops_done, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_res_valid", bus.res_valid, 0);
    check("post_rst_ops_done", ops_done, 0);

    // ops_done wrap with 256 zero-count commands
    for (int i = 0; i < 255; i++) begin
      send_cmd(4'(i), 1'b0, 3'd0, 4'(i), 1'b1);
      check("wrap_cmd_ready_done", bus.cmd_ready, 0);
    end
    drain();
    check("ops_255", ops_done, 255);
    send_cmd(4'b0110, 1'b1, 3'd0, 4'b0110, 1'b1);
    drain();
    check("ops_wrap", ops_done, 0);
    check("wrap_cmd_ready_idle", bus.cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
